yf_mem_arbiter: RTL and testbench

//   Shares the single yfcpu program/data memory among three requesters:

---
 rtl/yf_mem_pkg.sv | 25 ++
 rtl/yf_rr_pick3.sv | 24 ++
 rtl/yf_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_yf_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/yf_mem_pkg.sv
// Shared types and constants for the yfcpu memory arbiter.
package yf_mem_pkg;

  localparam logic [1:0] P_FETCH = 2'd0;
  localparam logic [1:0] P_DATA  = 2'd1;
  localparam logic [1:0] P_DBG   = 2'd2;

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // (base + step) mod 3 for base in 0..2, step in 1..3
  function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/yf_rr_pick3.sv
// Three-way round-robin picker: first eligible port after last, wrapping back to last.
module yf_rr_pick3
  import yf_mem_pkg::*;
(
  input  logic [2:0] eligible_i,
  input  logic [1:0] last_i,
  output logic       valid_o,
  output logic [1:0] winner_o
);

  logic [1:0] cand;

  // Walk the search order backwards so the earliest eligible candidate wins.
  always_comb begin
    cand     = '0;
    valid_o  = |eligible_i;
    winner_o = last_i;
    for (int i = 3; i >= 1; i--) begin
      cand = rr_step(last_i, 2'(i));
      if (eligible_i[cand]) winner_o = cand;
    end
  end

endmodule

// File: rtl/yf_mem_arbiter.sv
// Shares one synchronous-read SRAM port among fetch, load/store and debug requesters.
// Round-robin arbitration with a debug lock; one access in flight at a time.
module yf_mem_arbiter
  import yf_mem_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    req_i,
  input  logic [2:0]    we_i,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic [2:0]    ack_o,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  input  logic          dbg_lock,
  output logic          busy_o,
  output logic [1:0]    gnt_id_o,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  // state   | meaning
  // S_IDLE  | arbitrate among eligible requesters, latch the winner
  // S_ISSUE | strobe mem_en for one cycle, load latency counter
  // S_WAIT  | count down read latency, capture mem_rdata at zero
  // S_RESP  | pulse ack to the winner

  state_e           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    rdata_q [3];
  logic             cap;
  logic [2:0]       eligible;
  logic             pick_valid;
  logic [1:0]       pick_win;

  assign eligible = dbg_lock ? (req_i & 3'b100) : req_i;

  // win_q doubles as the round-robin pointer and the reported grant id.
  yf_rr_pick3 u_pick (
    .eligible_i (eligible),
    .last_i     (win_q),
    .valid_o    (pick_valid),
    .winner_o   (pick_win)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          win_d   = pick_win;
          we_d    = we_i[pick_win];
          state_d = S_ISSUE;
          unique case (pick_win)
            P_FETCH: begin addr_d = addr0; wdata_d = wdata0; end
            P_DATA:  begin addr_d = addr1; wdata_d = wdata1; end
            default: begin addr_d = addr2; wdata_d = wdata2; end
          endcase
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_W'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        if (cnt_q <= LAT_W'(1)) begin
          cap     = ~we_q;
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= P_DBG;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      if (cap) rdata_q[win_q] <= mem_rdata;
    end
  end

  assign mem_en    = (state_q == S_ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ack_o     = (state_q == S_RESP) ? (3'b001 << win_q) : 3'b000;
  assign busy_o    = (state_q != S_IDLE);
  assign gnt_id_o  = win_q;
  assign rdata0    = rdata_q[0];
  assign rdata1    = rdata_q[1];
  assign rdata2    = rdata_q[2];

endmodule

// File: tb/tb_yf_mem_arbiter.sv
// Scoreboard bench for yf_mem_arbiter; four instances with MEM_LAT = 1, 3, 4, 7,
// each backed by its own SRAM model preloaded with mem[a] = {8'hA5, a}.
module tb_yf_mem_arbiter;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst   [NI];
  logic [2:0]  req   [NI];
  logic [2:0]  we    [NI];
  logic [7:0]  addr  [NI][3];
  logic [15:0] wd    [NI][3];
  logic        dbg   [NI];
  logic [2:0]  ack   [NI];
  logic [15:0] rd    [NI][3];
  logic        busy  [NI];
  logic [1:0]  gnt   [NI];
  logic        men   [NI];
  logic        mwe   [NI];
  logic [7:0]  maddr [NI];
  logic [15:0] mwd   [NI];
  logic [15:0] mrd   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
    logic [15:0] mem  [256];
    logic [15:0] pipe [L];
    bit          init_done = 1'b0;

    always @(posedge clk) begin
      if (!init_done) begin
        for (int a = 0; a < 256; a++) mem[a] <= {8'hA5, 8'(a)};
        init_done <= 1'b1;
      end else if (men[g] && mwe[g]) begin
        mem[maddr[g]] <= mwd[g];
      end
      pipe[0] <= (men[g] && !mwe[g]) ? mem[maddr[g]] : 16'hDEAD;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd[g] = pipe[L-1];

    yf_mem_arbiter #(.AW(8), .DW(16), .MEM_LAT(L)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_i     (req[g]),
      .we_i      (we[g]),
      .addr0     (addr[g][0]),
      .addr1     (addr[g][1]),
      .addr2     (addr[g][2]),
      .wdata0    (wd[g][0]),
      .wdata1    (wd[g][1]),
      .wdata2    (wd[g][2]),
      .ack_o     (ack[g]),
      .rdata0    (rd[g][0]),
      .rdata1    (rd[g][1]),
      .rdata2    (rd[g][2]),
      .dbg_lock  (dbg[g]),
      .busy_o    (busy[g]),
      .gnt_id_o  (gnt[g]),
      .mem_en    (men[g]),
      .mem_we    (mwe[g]),
      .mem_addr  (maddr[g]),
      .mem_wdata (mwd[g]),
      .mem_rdata (mrd[g])
    );
  end

  typedef struct {
    int          inst;
    int          port;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic int lat(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input int k, input int p, input bit w, input logic [7:0] a, input logic [15:0] d);
    req[k][p]  = 1'b1;
    we[k][p]   = w;
    addr[k][p] = a;
    wd[k][p]   = d;
  endtask

  task automatic expect_ack(input int k, input int p, input logic [15:0] d, input int c);
    exp_t e;
    e.inst = k;
    e.port = p;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (q.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic run_vec(input int k, input int p, input bit w, input logic [7:0] a,
                         input logic [15:0] d, input logic [15:0] exp_rd);
    int c;
    c = cyc;
    drive(k, p, w, a, d);
    expect_ack(k, p, exp_rd, c + 2 + lat(k));
    wait_cyc(c + 2 + lat(k));
    req[k][p] = 1'b0;
    drain(20);
  endtask

  // Monitor: every ack pops the oldest expectation and checks it.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ack[k] != 3'b000) begin
        if (q.size() == 0) begin
          chk($sformatf("unexpected_ack_i%0d", k), 32'(ack[k]), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_inst",  32'(k),                  32'(e.inst));
          chk("ack_port",  32'(ack[k]),             32'(3'b001 << e.port));
          chk("ack_cycle", 32'(cyc),                32'(e.cyc));
          chk("ack_rdata", 32'(rd[k][e.port]),      32'(e.data));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c;
    int cnt;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1;
      req[k] = 3'b000;
      we[k]  = 3'b000;
      dbg[k] = 1'b0;
      for (int p = 0; p < 3; p++) begin
        addr[k][p] = 8'h00;
        wd[k][p]   = 16'h0000;
      end
    end
    step(2);
    for (int k = 0; k < NI; k++) begin
      chk("rst_mem_en", 32'(men[k]),  32'd0);
      chk("rst_ack",    32'(ack[k]),  32'd0);
      chk("rst_gnt_id", 32'(gnt[k]),  32'd2);
      chk("rst_busy",   32'(busy[k]), 32'd0);
      rst[k] = 1'b0;
    end
    step(1);

    // Single read on port 0
    c = cyc;
    drive(0, 0, 1'b0, 8'h10, 16'h0000);
    expect_ack(0, 0, 16'hA510, c + 3);
    step(1);
    chk("single_mem_en",   32'(men[0]),   32'd1);
    chk("single_mem_we",   32'(mwe[0]),   32'd0);
    chk("single_mem_addr", 32'(maddr[0]), 32'h10);
    wait_cyc(c + 3);
    req[0][0] = 1'b0;
    drain(10);
    chk("single_gnt_id", 32'(gnt[0]), 32'd0);

    // Reset mid-traffic: rst lands in the ISSUE cycle, held 2 cycles
    c = cyc;
    drive(0, 0, 1'b0, 8'h11, 16'h0000);
    step(1);
    rst[0]    = 1'b1;
    req[0][0] = 1'b0;
    step(1);
    chk("midrst_mem_en", 32'(men[0]),   32'd0);
    chk("midrst_ack",    32'(ack[0]),   32'd0);
    chk("midrst_gnt_id", 32'(gnt[0]),   32'd2);
    chk("midrst_busy",   32'(busy[0]),  32'd0);
    chk("midrst_rdata0", 32'(rd[0][0]), 32'd0);
    step(1);
    rst[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (ack[0] != 3'b000) cnt++;
    end
    chk("midrst_no_ack", 32'(cnt), 32'd0);

    // Round-robin with all three held high
    c = cyc;
    drive(0, 0, 1'b0, 8'h20, 16'h0000);
    drive(0, 1, 1'b0, 8'h21, 16'h0000);
    drive(0, 2, 1'b0, 8'h22, 16'h0000);
    expect_ack(0, 0, 16'hA520, c + 3);
    expect_ack(0, 1, 16'hA521, c + 7);
    expect_ack(0, 2, 16'hA522, c + 11);
    expect_ack(0, 0, 16'hA520, c + 15);
    expect_ack(0, 1, 16'hA521, c + 19);
    expect_ack(0, 2, 16'hA522, c + 23);
    wait_cyc(c + 23);
    req[0] = 3'b000;
    drain(10);

    // Debug lock blocks ports 0/1
    dbg[0] = 1'b1;
    drive(0, 0, 1'b0, 8'h05, 16'h0000);
    drive(0, 1, 1'b0, 8'h30, 16'h0000);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (men[0]) cnt++;
    end
    chk("lock_no_mem_en", 32'(cnt),     32'd0);
    chk("lock_busy",      32'(busy[0]), 32'd0);
    c = cyc;
    drive(0, 2, 1'b1, 8'h05, 16'hBEEF);
    expect_ack(0, 2, 16'hA522, c + 3);
    step(1);
    chk("lock_mem_en",    32'(men[0]),   32'd1);
    chk("lock_mem_we",    32'(mwe[0]),   32'd1);
    chk("lock_mem_addr",  32'(maddr[0]), 32'h05);
    chk("lock_mem_wdata", 32'(mwd[0]),   32'hBEEF);
    wait_cyc(c + 3);
    req[0][2] = 1'b0;
    dbg[0]    = 1'b0;
    expect_ack(0, 0, 16'hBEEF, c + 7);
    expect_ack(0, 1, 16'hA530, c + 11);
    wait_cyc(c + 7);
    req[0][0] = 1'b0;
    wait_cyc(c + 11);
    req[0][1] = 1'b0;
    drain(10);

    // Reset during WAIT with MEM_LAT = 4
    c = cyc;
    drive(2, 0, 1'b0, 8'h40, 16'h0000);
    step(2);
    rst[2]    = 1'b1;
    req[2][0] = 1'b0;
    step(1);
    chk("lat4_rst_busy",   32'(busy[2]), 32'd0);
    chk("lat4_rst_mem_en", 32'(men[2]),  32'd0);
    rst[2] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (ack[2] != 3'b000) cnt++;
    end
    chk("lat4_no_ack0", 32'(cnt), 32'd0);
    run_vec(2, 1, 1'b0, 8'h44, 16'h0000, 16'hA544);

    // Latency sweep
    run_vec(0, 1, 1'b0, 8'h61, 16'h0000, 16'hA561);
    run_vec(1, 2, 1'b0, 8'h62, 16'h0000, 16'hA562);
    run_vec(1, 0, 1'b1, 8'h70, 16'h1234, 16'h0000);
    run_vec(1, 0, 1'b0, 8'h70, 16'h0000, 16'h1234);
    run_vec(3, 1, 1'b0, 8'h63, 16'h0000, 16'hA563);
    run_vec(3, 2, 1'b1, 8'h77, 16'h5A5A, 16'h0000);
    run_vec(3, 2, 1'b0, 8'h77, 16'h0000, 16'h5A5A);

    step(3);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
